// File: rtl/bb_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : bb_frame_decoder
// Purpose  : Assembles framed bus-bridge requests from the UART receive byte
//            stream and presents them to the bridge master on a valid/ready
//            handshake. Stalled frames are dropped by an inter-byte timeout.
//            Bytes arriving while a request is held are dropped as overrun.
// Ports    : clk, rstn            - clock, asynchronous active-low reset
//            rx_data, rx_valid    - received byte and its one-cycle strobe
//            bb_addr, bb_wdata,   - assembled request fields
//            bb_mode                (1 = write, 0 = read)
//            req_valid, req_ready - request handshake
//            frame_err            - pulse: frame aborted by timeout
//            overrun              - pulse: byte dropped while holding
// Revision : 1.0 - initial release
// ============================================================================
module bb_frame_decoder #(
  parameter int BB_ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [BB_ADDR_WIDTH-1:0] bb_addr,
  output logic [DATA_WIDTH-1:0]    bb_wdata,
  output logic                     bb_mode,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_addr_lo = 2'd1;
  localparam logic [1:0] c_st_data    = 2'd2;
  localparam logic [1:0] c_st_hold    = 2'd3;

  localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_tmo_max  = c_cnt_w'(TIMEOUT_CYCLES);

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [c_cnt_w-1:0] r_tmo_cnt;
  logic               w_in_frame;
  logic               w_expire;
  logic               w_frame_err;
  logic               w_overrun;

  // Timeout only runs while a frame is partially received; a byte in the
  // expiry cycle takes priority over the abort.
  assign w_in_frame = (r_state == c_st_addr_lo) || (r_state == c_st_data);
  assign w_expire   = w_in_frame && !rx_valid && (r_tmo_cnt == c_tmo_last);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (rx_valid) w_state_next = c_st_addr_lo;
      end
      c_st_addr_lo: begin
        if (rx_valid)      w_state_next = bb_mode ? c_st_data : c_st_hold;
        else if (w_expire) w_state_next = c_st_idle;
      end
      c_st_data: begin
        if (rx_valid)      w_state_next = c_st_hold;
        else if (w_expire) w_state_next = c_st_idle;
      end
      c_st_hold: begin
        if (req_ready) w_state_next = c_st_idle;
      end
      default: w_state_next = c_st_idle;
    endcase
  end

  // Output logic
  always_comb begin
    req_valid   = (r_state == c_st_hold);
    w_overrun   = (r_state == c_st_hold) && rx_valid;
    w_frame_err = w_expire;
  end

  // Inter-byte timeout counter; any state change or received byte restarts it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tmo_cnt <= '0;
    end else if (rx_valid || (w_state_next != r_state)) begin
      r_tmo_cnt <= '0;
    end else if (w_in_frame && (r_tmo_cnt != c_tmo_max)) begin
      r_tmo_cnt <= r_tmo_cnt + c_cnt_w'(1);
    end
  end

  // Request fields and status pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bb_addr   <= '0;
      bb_wdata  <= '0;
      bb_mode   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= w_frame_err;
      overrun   <= w_overrun;
      if (w_expire) begin
        // Partial frame is discarded.
        bb_addr  <= '0;
        bb_wdata <= '0;
        bb_mode  <= 1'b0;
      end else if (rx_valid) begin
        case (r_state)
          c_st_idle: begin
            bb_mode                  <= rx_data[7];
            bb_addr[BB_ADDR_WIDTH-1:8] <= rx_data[BB_ADDR_WIDTH-9:0];
            bb_addr[7:0]             <= 8'h00;
            bb_wdata                 <= '0;
          end
          c_st_addr_lo: bb_addr[7:0] <= rx_data;
          c_st_data:    bb_wdata     <= rx_data;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/bb_frame_decoder.md
Name: bb_frame_decoder

Overview:
- Upstream neighbour of the bus-bridge address converter, inside the UART bus-bridge slave path.
- Takes the byte stream from the UART receiver and assembles framed requests, each with a mode, a bridge address and write data.
- Presents each request on a valid/ready handshake to the bridge master. That master routes bb_addr through the address converter onto the system bus.
- Recovers from framing faults: stalled frames are dropped by an inter-byte timeout, and bytes arriving while a request is held are dropped as overrun.

Parameters:
- BB_ADDR_WIDTH, 13: bridge address width. Legal range 9..15. The MSB selects the target slave and the lower bits are the in-slave address.
- DATA_WIDTH, 8: write data width. Fixed at one byte.
- TIMEOUT_CYCLES, 50000: maximum clk cycles allowed between bytes of one frame.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- bb_addr  out  BB_ADDR_WIDTH  assembled request address.
- bb_wdata  out  DATA_WIDTH  assembled write data. Zero for reads.
- bb_mode  out  1  1 = write, 0 = read.
- req_valid  out  1  request available.
- req_ready  in  1  master accepts the request.
- frame_err  out  1  one-cycle pulse when a frame is aborted by timeout.
- overrun  out  1  one-cycle pulse when a byte is dropped in HOLD.

Behaviour:
- Reset: clk and rstn are the only clock and reset. rstn is asynchronous and active-low. While rstn=0, all of the following are 0:
  - the FSM (state IDLE) and the timeout counter;
  - bb_addr, bb_wdata, bb_mode, req_valid, frame_err, overrun.
- Frame format:
  - Byte0 (header): bit7 = mode. Bits[BB_ADDR_WIDTH-9:0] = addr[BB_ADDR_WIDTH-1:8]. The remaining header bits are ignored.
  - Byte1: addr[7:0].
  - Byte2: write data. Present only when mode=1.
- FSM states: IDLE, ADDR_LO, DATA, HOLD.
- IDLE:
  - On rx_valid: latch mode and high address bits, clear bb_wdata, go to ADDR_LO.
- ADDR_LO:
  - On rx_valid: latch addr[7:0].
  - If mode=1, go to DATA.
  - If mode=0, go to HOLD and assert req_valid in the next cycle.
- DATA:
  - On rx_valid: latch bb_wdata, go to HOLD, assert req_valid.
- Request latency: req_valid rises one cycle after the clock edge that samples the final byte of the frame.
- HOLD:
  - req_valid=1. bb_addr, bb_wdata and bb_mode are stable.
  - Transfer occurs on a clock edge with req_valid=1 and req_ready=1. Go to IDLE; req_valid=0 in the next cycle.
  - req_ready may be high before req_valid. It has no effect outside HOLD.
  - Outputs hold their last values after transfer until overwritten by the next frame.
- Overrun:
  - rx_valid in HOLD: the byte is discarded and overrun pulses for one cycle.
  - This applies even in the transfer cycle itself. The byte does not start a new frame.
- Timeout:
  - The counter clears on every accepted rx_valid and on entry to any state.
  - It increments every cycle in ADDR_LO or DATA, saturating at TIMEOUT_CYCLES.
  - When the count reaches TIMEOUT_CYCLES-1 with no rx_valid in that cycle: go to IDLE, pulse frame_err for one cycle, discard partial fields. req_valid stays 0.
  - If rx_valid coincides with the expiry cycle, the byte wins and no error is raised.
- No timeout in IDLE or HOLD. HOLD waits indefinitely for req_ready.
- Reset mid-frame or in HOLD: everything clears immediately, and the pending request is lost without a handshake.
- Width rules:
  - Header bits above index BB_ADDR_WIDTH-9 are ignored.
  - For BB_ADDR_WIDTH=13, header bits[4:0] map to addr[12:8] and bits[6:5] are don't-care.

Test Plan:
- Write frame: bytes 0x93, 0x45, 0xA7 spaced 100 cycles apart, req_ready=1.
  -> bb_mode=1, bb_addr=0x1345, bb_wdata=0xA7. req_valid is high for exactly one cycle, one cycle after byte 3.
- Read frame: bytes 0x02, 0xFF, req_ready=0 for 20 cycles then 1.
  -> bb_mode=0, bb_addr=0x02FF, bb_wdata=0x00. req_valid is held 21 cycles with stable outputs and drops the cycle after the handshake.
- Timeout: TIMEOUT_CYCLES=16, send header 0x81 and then nothing.
  -> frame_err pulses once, 16 cycles after the header edge. req_valid stays 0.
  -> A following read frame 0x00, 0x10 decodes correctly to bb_addr=0x0010.
- Overrun: complete a write frame with req_ready=0, then send byte 0x55.
  -> overrun pulses once and bb_wdata keeps its value.
  -> After req_ready=1, the FSM returns to IDLE with no frame started by 0x55.
- Expiry race: with TIMEOUT_CYCLES=16, the second byte arrives exactly in the expiry cycle.
  -> No frame_err, and the frame completes normally.
- Reset mid-operation: assert rstn=0 asynchronously in DATA state and in HOLD.
  -> All outputs are 0 immediately. The next frame after release decodes correctly.
